// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared constants, state type and lane shaping helper
// for the rhythm-game note scheduler.
package rhythm_pkg;

  localparam int LANES = 4;

  // Random-word fields: lane pattern and spawn probability.
  localparam int PAT_MSB  = 7;
  localparam int PAT_LSB  = 4;
  localparam int PROB_MSB = 3;
  localparam int PROB_LSB = 0;

  // 5 bits so level 3 (16) beats every 4-bit probability.
  localparam logic [4:0] LVL_THRESH [0:3] = '{
    5'd4, 5'd8, 5'd12, 5'd16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Empty pattern falls back to one-hot from the beat index;
  // easy levels keep only the lowest lane.
  function automatic logic [LANES-1:0] shape_lane(
    input logic [LANES-1:0] pat,
    input logic [1:0]       lvl,
    input logic [1:0]       idx
  );
    logic [LANES-1:0] m;
    m = pat;
    if (m == '0)
      m = {{(LANES-1){1'b0}}, 1'b1} << idx;
    if (lvl < 2'd2)
      m = m & (~m + 1'b1);
    return m;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// beat_timer: free-running beat counter with clear and enable.
// Ports: clk, rst (sync), clr, en in; tick out while count is last.
module beat_timer #(
  parameter int CLK_PER_BEAT = 25_000_000,
  parameter int CNT_W        = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BEAT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: beat-synchronous note spawner with valid/ready out.
// In: i_Clk, i_Rst, i_Start, i_Stop, i_Level, i_Rand, i_Note_Ready.
// Out: o_Note_Valid, o_Note_Lane, o_Beat_Idx, o_Busy, o_Drop.
module note_scheduler
  import rhythm_pkg::*;
#(
  parameter int CLK_PER_BEAT = 25_000_000,
  parameter int CNT_W        = 25
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Stop,
  input  logic [1:0]       i_Level,
  input  logic [7:0]       i_Rand,
  output logic             o_Note_Valid,
  input  logic             i_Note_Ready,
  output logic [LANES-1:0] o_Note_Lane,
  output logic [7:0]       o_Beat_Idx,
  output logic             o_Busy,
  output logic             o_Drop
);

  state_t           state;
  state_t           state_nxt;
  logic             tick;
  logic             tmr_clr;
  logic             tmr_en;
  logic             xfer;
  logic             spawn;
  logic [7:0]       idx_nxt;
  logic [LANES-1:0] lane_nxt;

  assign tmr_clr = (state == IDLE) || i_Stop;
  assign tmr_en  = (state != IDLE);

  beat_timer #(
    .CLK_PER_BEAT (CLK_PER_BEAT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tick (tick)
  );

  // Beat evaluation; lane uses the index after this tick's increment.
  always_comb begin
    xfer     = o_Note_Valid & i_Note_Ready;
    idx_nxt  = o_Beat_Idx + 8'd1;
    spawn    = {1'b0, i_Rand[PROB_MSB:PROB_LSB]}
               < LVL_THRESH[i_Level];
    lane_nxt = shape_lane(i_Rand[PAT_MSB:PAT_LSB],
                          i_Level, idx_nxt[1:0]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_Start) state_nxt = RUN;
      RUN:  if (tick && spawn) state_nxt = EMIT;
      EMIT: begin
        if (tick)
          state_nxt = spawn ? EMIT : RUN;
        else if (xfer)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_Stop)
      state_nxt = IDLE;
  end

  always_comb begin
    o_Busy = (state != IDLE);
  end

  // A tick in EMIT without a same-cycle transfer discards the note.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Stop) begin
      o_Note_Valid <= 1'b0;
      o_Note_Lane  <= '0;
      o_Beat_Idx   <= 8'd0;
      o_Drop       <= 1'b0;
    end else begin
      o_Drop <= tick && (state == EMIT) && !xfer;
      if (tick) begin
        o_Beat_Idx   <= idx_nxt;
        o_Note_Valid <= spawn;
        if (spawn)
          o_Note_Lane <= lane_nxt;
      end else if (xfer) begin
        o_Note_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: vector table, hand sequences and a randomized
// beat-level reference model for note_scheduler with 8 clocks/beat.
module tb_note_scheduler;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] level;
  logic [7:0] rnd;
  logic       ready;
  logic       valid;
  logic [3:0] lane;
  logic [7:0] idx;
  logic       busy;
  logic       drop;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_idx;

  always #5 clk = ~clk;

  note_scheduler #(
    .CLK_PER_BEAT (CPB),
    .CNT_W        (4)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start),
    .i_Stop       (stop),
    .i_Level      (level),
    .i_Rand       (rnd),
    .o_Note_Valid (valid),
    .i_Note_Ready (ready),
    .o_Note_Lane  (lane),
    .o_Beat_Idx   (idx),
    .o_Busy       (busy),
    .o_Drop       (drop)
  );

  typedef struct {
    logic [1:0] lvl;
    logic [7:0] r;
    logic       v;
    logic [3:0] ln;
    logic [7:0] ix;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic ref_spawn(input int l, input int r);
    return (r % 16) < 4 * (l + 1);
  endfunction

  function automatic logic [3:0] ref_lane(
    input int l, input int r, input int ix
  );
    int p;
    int low;
    p = r / 16;
    if (p == 0) return 4'(1 << (ix % 4));
    if (l >= 2) return 4'(p);
    low = 0;
    for (int b = 3; b >= 0; b--)
      if (((p >> b) & 1) == 1) low = b;
    return 4'(1 << low);
  endfunction

  // Called at the negedge after a tick edge; returns at the next one.
  task automatic beat(
    input  logic [1:0] l,
    input  logic [7:0] r,
    input  logic       rd,
    output logic       mv,
    output logic       md
  );
    level = l;
    rnd   = r;
    ready = rd;
    @(posedge clk);
    @(negedge clk);
    mv = valid;
    md = drop;
    repeat (CPB - 1) @(posedge clk);
    @(negedge clk);
    exp_idx++;
  endtask

  task automatic start_run(
    input logic [1:0] l, input logic [7:0] r, input logic rd
  );
    level = l;
    rnd   = r;
    ready = rd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    @(negedge clk);
    chk("pre_tick_valid", valid, 0);
    chk("run_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    exp_idx = 8'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic mv;
    logic md;
    logic prev;
    logic es;
    int   notes;

    tbl[0]  = '{2'd0, 8'hB9, 1'b0, 4'b0000, 8'd2};
    tbl[1]  = '{2'd2, 8'hB3, 1'b1, 4'b1011, 8'd3};
    tbl[2]  = '{2'd3, 8'h0F, 1'b1, 4'b0001, 8'd4};
    tbl[3]  = '{2'd3, 8'h0F, 1'b1, 4'b0010, 8'd5};
    tbl[4]  = '{2'd3, 8'h0F, 1'b1, 4'b0100, 8'd6};
    tbl[5]  = '{2'd1, 8'h63, 1'b1, 4'b0010, 8'd7};
    tbl[6]  = '{2'd2, 8'h6B, 1'b1, 4'b0110, 8'd8};
    tbl[7]  = '{2'd1, 8'h07, 1'b1, 4'b0010, 8'd9};
    tbl[8]  = '{2'd0, 8'hF0, 1'b1, 4'b0001, 8'd10};
    tbl[9]  = '{2'd1, 8'h08, 1'b0, 4'b0000, 8'd11};
    tbl[10] = '{2'd2, 8'h6C, 1'b0, 4'b0000, 8'd12};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    level = 2'd0; rnd = 8'd0; ready = 1'b0;
    exp_idx = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_lane", lane, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    rst = 1'b0;
    @(negedge clk);

    // First note: level 0, 8'hB3, ready high.
    start_run(2'd0, 8'hB3, 1'b1);
    chk("first_valid", valid, 1);
    chk("first_lane", lane, 4'b0001);
    chk("first_idx", idx, 1);

    foreach (tbl[i]) begin
      beat(tbl[i].lvl, tbl[i].r, 1'b1, mv, md);
      chk("tbl_mid_valid", mv, 0);
      chk("tbl_mid_drop", md, 0);
      chk("tbl_valid", valid, tbl[i].v);
      chk("tbl_idx", idx, tbl[i].ix);
      chk("tbl_drop", drop, 0);
      if (tbl[i].v) chk("tbl_lane", lane, tbl[i].ln);
    end

    // Ready held low across a beat: drop and replace.
    beat(2'd0, 8'h51, 1'b0, mv, md);
    chk("hold_valid", valid, 1);
    chk("hold_lane", lane, 4'b0001);
    chk("hold_drop", drop, 0);
    level = 2'd2;
    @(posedge clk);
    @(negedge clk);
    chk("held_valid", valid, 1);
    chk("held_lane", lane, 4'b0001);
    repeat (CPB - 1) @(posedge clk);
    @(negedge clk);
    exp_idx++;
    chk("drop_pulse", drop, 1);
    chk("drop_valid", valid, 1);
    chk("drop_lane", lane, 4'b0101);
    chk("drop_idx", idx, exp_idx);
    @(posedge clk);
    @(negedge clk);
    chk("drop_one_cycle", drop, 0);
    chk("drop_keep_valid", valid, 1);
    chk("drop_keep_lane", lane, 4'b0101);
    repeat (CPB - 2) @(posedge clk);
    @(negedge clk);
    // Ready rises in the tick cycle: transfer, no drop.
    ready = 1'b1;
    rnd   = 8'h92;
    @(posedge clk);
    @(negedge clk);
    exp_idx++;
    chk("tick_xfer_drop", drop, 0);
    chk("tick_xfer_valid", valid, 1);
    chk("tick_xfer_lane", lane, 4'b1001);
    chk("tick_xfer_idx", idx, exp_idx);

    // Randomized beats against the beat-level model.
    prev = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] l;
      logic [7:0] r;
      logic       rd;
      l  = 2'($urandom_range(0, 3));
      r  = 8'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      beat(l, r, rd, mv, md);
      es = ref_spawn(int'(l), int'(r));
      chk("rnd_mid_valid", mv, prev & ~rd);
      chk("rnd_mid_drop", md, 0);
      chk("rnd_drop", drop, prev & ~rd);
      chk("rnd_valid", valid, es);
      chk("rnd_idx", idx, exp_idx);
      if (es)
        chk("rnd_lane", lane,
            ref_lane(int'(l), int'(r), int'(exp_idx)));
      prev = es;
    end

    // Stop during EMIT, then restart.
    beat(2'd3, 8'h12, 1'b0, mv, md);
    chk("pre_stop_valid", valid, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_valid", valid, 0);
    chk("stop_idx", idx, 0);
    chk("stop_busy", busy, 0);
    chk("stop_drop", drop, 0);
    start_run(2'd3, 8'h40, 1'b1);
    chk("restart_valid", valid, 1);
    chk("restart_lane", lane, 4'b0100);
    chk("restart_idx", idx, 1);

    // Start together with stop: stop wins.
    stop = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    chk("start_stop_valid", valid, 0);
    chk("start_stop_idx", idx, 0);

    // 256 beats at level 3: every beat spawns, index wraps.
    start_run(2'd3, 8'h00, 1'b1);
    notes = int'(valid);
    chk("wrap_first_lane", lane, 4'b0010);
    for (int n = 1; n < 256; n++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      beat(2'd3, r, 1'b1, mv, md);
      notes += int'(valid);
      chk("wrap_idx", idx, exp_idx);
      chk("wrap_lane", lane, ref_lane(3, int'(r), int'(exp_idx)));
    end
    chk("wrap_notes", notes, 256);
    chk("wrap_zero", idx, 0);

    // Reset held two cycles while a note is pending.
    beat(2'd3, 8'h33, 1'b0, mv, md);
    chk("pre_rst_valid", valid, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_lane", lane, 0);
    chk("mid_rst_idx", idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop, 0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_idx", idx, 0);
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
